// File: rtl/activation_feeder.sv
// Purpose   : buffers activation pairs and, on start, issues LOAD_WEIGHT then streams
//             them into the 2x2 systolic array with the row-1 diagonal skew.
// Latency   : start -> done is N+4 cycles (N+3 without skew); start with empty FIFO -> done next cycle.
// Backpress : none from the array; writes while full are dropped, caller watches full/count.
//
// Ports: clk/reset (async active-low); wr_en/wr_data1/wr_data2 push a pair; full/count FIFO status;
//        start/base_address launch a job; busy/done job status; instruction/valid/a_in1/a_in2 to array.
// Build option: define FEEDER_SKEW_EN to delay a_in2 by one cycle (adds the DRAIN cycle).

// Generic single-clock FIFO with occupancy count.
// Latency: head_dat shows the oldest entry combinationally; count updates on the next edge.
// Backpressure: push_vld while full is dropped; pop_rdy on an empty FIFO is ignored.
module feeder_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_rdy,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == FULL_CNT);
    assign count    = cnt;
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && (cnt != '0);
    assign head_dat = mem[rd_ptr];

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module activation_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 13
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data1,
    input  logic [DATA_W-1:0]          wr_data2,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_address,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                instruction,
    output logic                       valid,
    output logic [DATA_W-1:0]          a_in1,
    output logic [DATA_W-1:0]          a_in2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
    } pair_t;

    typedef enum logic [2:0] {IDLE, LOADW, WAIT, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_left;   // pops still owed to the current job
    pair_t            wr_pair;
    pair_t            head;
    logic             pop;
`ifdef FEEDER_SKEW_EN
    logic [DATA_W-1:0] d2_q;    // data2 of the previous pop, delayed for row 1
`endif

    assign wr_pair = '{data1: wr_data1, data2: wr_data2};

    // Outputs are registered, so the pop for each STREAM cycle happens on the
    // edge that enters it: the first pop is taken while still in WAIT.
    assign pop = (state == WAIT) || ((state == STREAM) && (n_left != '0));

    feeder_fifo #(
        .W     ($bits(pair_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .arst_n   (reset),
        .push_vld (wr_en),
        .push_dat (wr_pair),
        .pop_rdy  (pop),
        .head_dat (head),
        .count    (count),
        .full     (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            n_left      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instruction <= 16'h0000;
            valid       <= 1'b0;
            a_in1       <= '0;
            a_in2       <= '0;
`ifdef FEEDER_SKEW_EN
            d2_q        <= '0;
`endif
        end else begin
            instruction <= 16'h0000;
            valid       <= 1'b0;
            a_in1       <= '0;
            a_in2       <= '0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // N is the occupancy at start; later writes wait for the next job.
                            state       <= LOADW;
                            busy        <= 1'b1;
                            n_left      <= count;
                            instruction <= {3'b001, 13'(base_address)};
                        end
                    end
                end
                LOADW: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state  <= STREAM;
                    valid  <= 1'b1;
                    a_in1  <= head.data1;
                    n_left <= n_left - 1'b1;
`ifdef FEEDER_SKEW_EN
                    a_in2  <= '0;
                    d2_q   <= head.data2;
`else
                    a_in2  <= head.data2;
`endif
                end
                STREAM: begin
                    if (n_left != '0) begin
                        valid  <= 1'b1;
                        a_in1  <= head.data1;
                        n_left <= n_left - 1'b1;
`ifdef FEEDER_SKEW_EN
                        a_in2  <= d2_q;
                        d2_q   <= head.data2;
`else
                        a_in2  <= head.data2;
`endif
                    end else begin
`ifdef FEEDER_SKEW_EN
                        // Flush the last row-1 element.
                        state <= DRAIN;
                        valid <= 1'b1;
                        a_in2 <= d2_q;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_activation_feeder.sv
// Bench for activation_feeder: random pairs, a queue-based reference of the FIFO and
// per-cycle expected outputs derived from the job timeline. Follows FEEDER_SKEW_EN.
module tb_activation_feeder;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 13;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data1;
    logic [DATA_W-1:0] wr_data2;
    logic              full;
    logic [3:0]        count;
    logic              start;
    logic [ADDR_W-1:0] base_address;
    logic              busy;
    logic              done;
    logic [15:0]       instruction;
    logic              valid;
    logic [DATA_W-1:0] a_in1;
    logic [DATA_W-1:0] a_in2;

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
    } ent_t;

    ent_t q[$];
    int   n_checks;
    int   n_fail;

    activation_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data1     (wr_data1),
        .wr_data2     (wr_data2),
        .full         (full),
        .count        (count),
        .start        (start),
        .base_address (base_address),
        .busy         (busy),
        .done         (done),
        .instruction  (instruction),
        .valid        (valid),
        .a_in1        (a_in1),
        .a_in2        (a_in2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " instr"}, 32'(instruction), 32'h0);
        check({tag, " valid"}, 32'(valid), 32'h0);
        check({tag, " a_in1"}, 32'(a_in1), 32'h0);
        check({tag, " a_in2"}, 32'(a_in2), 32'h0);
        check({tag, " busy"},  32'(busy), 32'h0);
        check({tag, " done"},  32'(done), 32'h0);
        check({tag, " count"}, 32'(count), 32'(q.size()));
        check({tag, " full"},  32'(full), 32'(q.size() == DEPTH));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic push(input logic [15:0] d1, input logic [15:0] d2);
        ent_t e;
        e.d1 = d1;
        e.d2 = d2;
        wr_en    = 1'b1;
        wr_data1 = d1;
        wr_data2 = d2;
        if (q.size() < DEPTH) q.push_back(e);
        @(negedge clk);
        wr_en = 1'b0;
        check("push count", 32'(count), 32'(q.size()));
        check("push full",  32'(full), 32'(q.size() == DEPTH));
    endtask

    // One job, checked cycle by cycle. k counts cycles after the edge sampling start.
    // n_extra pairs are pushed during streaming; caller keeps them within free space and N.
    task automatic run_job(input logic [12:0] base, input int n_extra);
        ent_t        exp_q[$];
        ent_t        e;
        int          n;
        int          last_k;
        int          extra;
        logic [31:0] e_instr, e_valid, e_a1, e_a2, e_busy, e_done;
        string       tag;

        n     = q.size();
        exp_q = q;
        extra = n_extra;
        start        = 1'b1;
        base_address = base;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) last_k = 1;
`ifdef FEEDER_SKEW_EN
        else last_k = n + 4;
`else
        else last_k = n + 3;
`endif
        for (int k = 1; k <= last_k + 1; k++) begin
            e_instr = 0; e_valid = 0; e_a1 = 0; e_a2 = 0; e_busy = 0; e_done = 0;
            if (n == 0) begin
                if (k == 1) e_done = 1;
            end else begin
                if (k < last_k) e_busy = 1;
                if (k == 1) e_instr = 32'({3'b001, base});
                if (k >= 3 && k <= 2 + n) begin
                    e_valid = 1;
                    e_a1    = 32'(exp_q[k-3].d1);
`ifdef FEEDER_SKEW_EN
                    if (k > 3) e_a2 = 32'(exp_q[k-4].d2);
`else
                    e_a2 = 32'(exp_q[k-3].d2);
`endif
                end
`ifdef FEEDER_SKEW_EN
                if (k == 3 + n) begin
                    e_valid = 1;
                    e_a2    = 32'(exp_q[n-1].d2);
                end
`endif
                if (k == last_k) e_done = 1;
            end
            tag = $sformatf("job n=%0d k=%0d", n, k);
            check({tag, " instr"}, 32'(instruction), e_instr);
            check({tag, " valid"}, 32'(valid), e_valid);
            check({tag, " a_in1"}, 32'(a_in1), e_a1);
            check({tag, " a_in2"}, 32'(a_in2), e_a2);
            check({tag, " busy"},  32'(busy), e_busy);
            check({tag, " done"},  32'(done), e_done);
            // start while busy and in the DONE cycle must have no effect.
            start = ((k == 2 && n > 0) || k == last_k) ? 1'b1 : 1'b0;
            base_address = 13'($urandom);
            if (extra > 0 && k >= 3 && k <= 2 + n) begin
                e.d1 = 16'($urandom);
                e.d2 = 16'($urandom);
                wr_en    = 1'b1;
                wr_data1 = e.d1;
                wr_data2 = e.d2;
                q.push_back(e);
                extra--;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) void'(q.pop_front());
        check("after job count", 32'(count), 32'(q.size()));
        check("after job full",  32'(full), 32'(q.size() == DEPTH));
    endtask

    initial begin
        int n;
        int extra;
        int npush;

        n_checks = 0;
        n_fail   = 0;
        reset        = 1'b0;
        wr_en        = 1'b0;
        wr_data1     = '0;
        wr_data2     = '0;
        start        = 1'b0;
        base_address = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;
        @(negedge clk);
        check_quiet("post reset");

        // Reset in the middle of streaming.
        for (int i = 0; i < 4; i++) push(16'($urandom), 16'($urandom));
        start        = 1'b1;
        base_address = 13'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid stream valid", 32'(valid), 32'h1);
        reset = 1'b0;
        q.delete();
        #1;
        check_quiet("async reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("after mid reset");
        run_job(13'($urandom), 0);

        // Basic job with known data and address.
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        run_job(13'h0A0, 0);

        // Empty start.
        run_job(13'h1FFF, 0);

        // Overflow: the ninth push is dropped by both model and DUT.
        for (int i = 0; i < DEPTH + 1; i++) push(16'($urandom), 16'($urandom));
        run_job(13'($urandom), 0);

        // Writes during streaming are kept for the next job.
        push(16'($urandom), 16'($urandom));
        push(16'($urandom), 16'($urandom));
        run_job(13'($urandom), 1);
        run_job(13'($urandom), 0);

        // Random jobs, including overflow attempts and concurrent writes.
        for (int it = 0; it < 16; it++) begin
            npush = $urandom_range(0, DEPTH + 1);
            for (int i = 0; i < npush; i++) push(16'($urandom), 16'($urandom));
            n     = q.size();
            extra = $urandom_range(0, 3);
            if (extra > n) extra = n;
            if (extra > DEPTH - n) extra = DEPTH - n;
            run_job(13'($urandom), extra);
        end

        check_quiet("final idle");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/activation_feeder.md
# activation_feeder

Upstream stage of the 2x2 systolic-array top level. It buffers activation vector pairs in a small FIFO. On `start` it issues one LOAD_WEIGHT instruction, then streams the buffered vectors into the array's `a_in1`/`a_in2` ports with `valid`, applying the one-cycle diagonal skew the array expects on row 1. It drives the top level's `instruction`, `valid`, `a_in1` and `a_in2` inputs directly.

## Interface

Parameters:
- `DATA_W`, 16: activation element width.
- `DEPTH`, 8: FIFO depth in vector pairs; must be a power of two.
- `ADDR_W`, 13: weight base-address width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push `{wr_data1, wr_data2}` into the FIFO.
- `wr_data1` in DATA_W: column-0 element, destined for `a_in1`.
- `wr_data2` in DATA_W: column-1 element, destined for `a_in2`.
- `full` out 1: FIFO holds DEPTH entries (combinational from count).
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `start` in 1: begin one weight-load-plus-stream job.
- `base_address` in ADDR_W: weight address, sampled with `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job end.
- `instruction` out 16: to the control unit.
- `valid` out 1: activation data valid.
- `a_in1` out DATA_W: row-0 activation.
- `a_in2` out DATA_W: row-1 activation.

## Operation

- Instruction encoding: LOAD_WEIGHT = {3'b001, base_address[12:0]}; NOP = 16'h0000. `instruction` is NOP whenever no LOAD_WEIGHT is being issued.
- FIFO:
  - `wr_en` while `full` is dropped; contents are unchanged.
  - Writes are accepted in every state, including during streaming.
  - A write and a pop in the same cycle both take effect, so `count` is unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, LOADW, WAIT, STREAM, DRAIN, DONE.
- IDLE:
  - `start` with `count`==0: go to DONE and issue no instruction.
  - `start` with `count`>0: latch N=`count` and `base_address`, then go to LOADW.
- LOADW (1 cycle): `instruction`=LOAD_WEIGHT. Next state WAIT.
- WAIT (1 cycle): `instruction`=NOP; gives the array time to latch weights. Next state STREAM.
- STREAM (N cycles):
  - Pop one entry per cycle; `valid`=1; `a_in1` = popped `.data1`.
  - `a_in2` = `.data2` of the previous pop; 0 in the first STREAM cycle.
  - Leave STREAM after N pops. Entries written after `start` are not streamed in this job.
- DRAIN (1 cycle): `valid`=1, `a_in1`=0, `a_in2` = `.data2` of the last pop.
- DONE (1 cycle): `done`=1, `busy`=0. Next state IDLE.
- `busy`=1 in LOADW, WAIT, STREAM and DRAIN.
- `start` is ignored whenever the FSM is not in IDLE.
- `valid`=0, `a_in1`=0 and `a_in2`=0 in every state other than STREAM and DRAIN.
- Reset, including mid-job:
  - Outputs: `busy`, `done`, `valid`, `a_in1`, `a_in2` and `instruction` go to 0; `count` goes to 0; `full` goes to 0.
  - State: FIFO emptied (both pointers 0); FSM to IDLE.

## Timing

- All outputs except `full` and `count` are registered.
- Job with N>0, `start` sampled at edge T:
  - T+1: `instruction`=LOAD_WEIGHT.
  - T+2: WAIT.
  - T+3 .. T+2+N: STREAM.
  - T+3+N: DRAIN.
  - T+4+N: `done` pulse.
  - Total latency from `start` to `done` is N+4 cycles.
- `busy` is high from T+1 through T+3+N.
- `start` may be asserted in the same cycle that `done` is high; it is ignored that cycle because the FSM is still in DONE. Back-to-back jobs are therefore spaced by at least one cycle.
- Job with N=0: `done` at T+1; `busy` stays 0.
- `count`/`full` update on the edge after the write or pop.

## Configuration

- `FEEDER_SKEW_EN`:
  - Defined: row-1 skew as described, including the DRAIN state.
  - Undefined: `a_in2` = popped `.data2` in the same cycle as `a_in1`; DRAIN is skipped. `done` then falls at T+3+N and `busy` is high T+1..T+2+N.

## Test plan

- Reset mid-STREAM (with skew): push 4 pairs, `start`, drop `reset` at T+4 -> all outputs 0, `count`=0, state IDLE. Next `start` -> `done` at the next edge, no LOAD_WEIGHT.
- Basic job (skew): push (1,2),(3,4),(5,6); `start` with base 13'h0A0 -> `instruction`=16'h20A0 at T+1. `a_in1`=1,3,5,0 and `a_in2`=0,2,4,6 over T+3..T+6 with `valid`=1. `done` at T+7.
- Empty start: `start` with `count`=0 -> `done` at T+1; `instruction`, `valid` and `busy` stay 0.
- Full/overflow: push 9 pairs into DEPTH=8 -> `full`=1 after the 8th push; 9th is dropped; streaming yields exactly the first 8.
- Concurrent write: `start` with 2 entries, push (7,8) during STREAM -> only 2 streamed; `count`=1 after `done`; `start` again streams (7,8).
- Skew disabled (build without `FEEDER_SKEW_EN`): push (1,2),(3,4) -> `a_in1`=1,3 and `a_in2`=2,4 at T+3..T+4; `done` at T+5.
